mc_control: RTL and testbench

Multicycle control unit for the MIPS core, replacing the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, so the datapath can share one memory port and one ALU, and it stalls on a memory ready handshake. It decodes the same opcode set as the current core (R-type, ADDI, ADDIU, ANDI, LW, SW, BEQ, BNE, J, JAL), traps illegal opcodes and counts retired instructions.

---
 rtl/mc_control.sv | 203 ++++++++++++++++++++
 tb/tb_mc_control.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control unit. Sequences FETCH/DECODE/EXEC/MEM/WB
// over a shared memory port and ALU, traps illegal opcodes and counts retired
// instructions. Control outputs are decoded combinationally from the current
// state, the latched opcode and the live alu_zero/mem_ready inputs.
module mc_control #(
    parameter int unsigned ALUOP_W     = 4,
    parameter bit          MEM_WAIT_EN = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [5:0]         opcode,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               mux_iord,
    output logic               read_mem,
    output logic               write_mem,
    output logic               write_reg,
    output logic [1:0]         mux_write_rt_rd_cnst,
    output logic               mux_alu_src_reg_imm,
    output logic [1:0]         mux_reg_src_alu_mem_pc,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUBEQ = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_SUBNE = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire_c;
    logic               mem_done_c;

    // With waiting disabled every memory access completes in its first cycle.
    assign mem_done_c = mem_ready | ~MEM_WAIT_EN;

    assign state   = state_q;
    assign retired = retired_q;

    // State, latched opcode and retirement counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_FETCH;
            op_q      <= 6'h00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and control decode; everything idles while nrst is low.
    always_comb begin
        state_d                = state_q;
        op_d                   = op_q;
        retire_c               = 1'b0;
        ir_write               = 1'b0;
        pc_write               = 1'b0;
        pc_src                 = 2'b00;
        mux_iord               = 1'b0;
        read_mem               = 1'b0;
        write_mem              = 1'b0;
        write_reg              = 1'b0;
        mux_write_rt_rd_cnst   = 2'b01;
        mux_alu_src_reg_imm    = 1'b0;
        mux_reg_src_alu_mem_pc = 2'b01;
        alu_op                 = ALUOP_W'(ALU_FUNCT);
        illegal                = 1'b0;

        if (nrst) begin
            case (state_q)
                S_FETCH: begin
                    read_mem = 1'b1;
                    if (mem_done_c) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_d = opcode;
                    case (opcode)
                        OP_J: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b10;
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
                        OP_JAL: begin
                            pc_write               = 1'b1;
                            pc_src                 = 2'b10;
                            write_reg              = 1'b1;
                            mux_write_rt_rd_cnst   = 2'b10;
                            mux_reg_src_alu_mem_pc = 2'b10;
                            retire_c               = 1'b1;
                            state_d                = S_FETCH;
                        end
                        OP_R, OP_ADDI, OP_ADDIU, OP_ANDI,
                        OP_LW, OP_SW, OP_BEQ, OP_BNE: state_d = S_EXEC;
                        default: state_d = S_TRAP;
                    endcase
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R: state_d = S_WB;
                        OP_ADDI, OP_ADDIU: begin
                            alu_op              = ALUOP_W'(ALU_ADD);
                            mux_alu_src_reg_imm = 1'b1;
                            state_d             = S_WB;
                        end
                        OP_ANDI: begin
                            alu_op              = ALUOP_W'(ALU_AND);
                            mux_alu_src_reg_imm = 1'b1;
                            state_d             = S_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_op              = ALUOP_W'(ALU_ADD);
                            mux_alu_src_reg_imm = 1'b1;
                            state_d             = S_MEM;
                        end
                        OP_BEQ: begin
                            alu_op   = ALUOP_W'(ALU_SUBEQ);
                            pc_src   = 2'b01;
                            pc_write = alu_zero;
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
                        OP_BNE: begin
                            alu_op   = ALUOP_W'(ALU_SUBNE);
                            pc_src   = 2'b01;
                            pc_write = ~alu_zero;
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
                        default: state_d = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    mux_iord = 1'b1;
                    if (op_q == OP_SW) begin
                        write_mem = 1'b1;
                    end else begin
                        read_mem = 1'b1;
                    end
                    if (mem_done_c) begin
                        if (op_q == OP_SW) begin
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    write_reg = 1'b1;
                    if (op_q == OP_LW) begin
                        mux_write_rt_rd_cnst   = 2'b00;
                        mux_reg_src_alu_mem_pc = 2'b00;
                    end else if (op_q != OP_R) begin
                        mux_write_rt_rd_cnst = 2'b00;
                    end
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
                S_TRAP: illegal = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end

        retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;
    end

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control: per-cycle vector table for the default build and a
// short hand sequence for a no-wait, 2-bit-counter build.
module tb_mc_control;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance.
    logic       nrst_a, z_a, rdy_a;
    logic [5:0] op_a;
    logic       irw_a, pcw_a, iord_a, rd_a, wr_a, wreg_a, asrc_a, ill_a;
    logic [1:0] pcs_a, dest_a, data_a;
    logic [3:0] aop_a;
    logic [2:0] st_a;
    logic [31:0] ret_a;

    mc_control dut_a (
        .clk(clk), .nrst(nrst_a), .opcode(op_a), .alu_zero(z_a), .mem_ready(rdy_a),
        .ir_write(irw_a), .pc_write(pcw_a), .pc_src(pcs_a), .mux_iord(iord_a),
        .read_mem(rd_a), .write_mem(wr_a), .write_reg(wreg_a),
        .mux_write_rt_rd_cnst(dest_a), .mux_alu_src_reg_imm(asrc_a),
        .mux_reg_src_alu_mem_pc(data_a), .alu_op(aop_a), .state(st_a),
        .illegal(ill_a), .retired(ret_a)
    );

    // No memory wait, 2-bit retired counter.
    logic       nrst_b, z_b, rdy_b;
    logic [5:0] op_b;
    logic       irw_b, pcw_b, iord_b, rd_b, wr_b, wreg_b, asrc_b, ill_b;
    logic [1:0] pcs_b, dest_b, data_b;
    logic [3:0] aop_b;
    logic [2:0] st_b;
    logic [1:0] ret_b;

    mc_control #(.ALUOP_W(4), .MEM_WAIT_EN(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .nrst(nrst_b), .opcode(op_b), .alu_zero(z_b), .mem_ready(rdy_b),
        .ir_write(irw_b), .pc_write(pcw_b), .pc_src(pcs_b), .mux_iord(iord_b),
        .read_mem(rd_b), .write_mem(wr_b), .write_reg(wreg_b),
        .mux_write_rt_rd_cnst(dest_b), .mux_alu_src_reg_imm(asrc_b),
        .mux_reg_src_alu_mem_pc(data_b), .alu_op(aop_b), .state(st_b),
        .illegal(ill_b), .retired(ret_b)
    );

    // stb = {ir_write, pc_write, read_mem, write_mem, write_reg}
    typedef struct packed {
        logic [2:0]  st;
        logic [4:0]  stb;
        logic [1:0]  ps;
        logic        io;
        logic [1:0]  d;
        logic        as;
        logic [1:0]  dt;
        logic [3:0]  ao;
        logic        il;
        logic [31:0] ret;
    } exp_t;

    typedef struct {
        logic       n;
        logic [5:0] op;
        logic       z;
        logic       r;
        exp_t       e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t v(logic n, logic [5:0] op, logic z, logic r,
                               logic [2:0] st, logic [4:0] stb, logic [1:0] ps,
                               logic io, logic [1:0] d, logic as, logic [1:0] dt,
                               logic [3:0] ao, logic il, logic [31:0] ret);
        vec_t x;
        x.n = n; x.op = op; x.z = z; x.r = r;
        x.e.st = st; x.e.stb = stb; x.e.ps = ps; x.e.io = io; x.e.d = d;
        x.e.as = as; x.e.dt = dt; x.e.ao = ao; x.e.il = il; x.e.ret = ret;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_b(input logic n, input logic [5:0] op, input logic r);
        @(negedge clk);
        nrst_b = n; op_b = op; rdy_b = r; z_b = 1'b0;
        #2;
    endtask

    exp_t act, want;

    initial begin
        nrst_a = 1'b0; op_a = 6'h23; z_a = 1'b0; rdy_a = 1'b1;
        nrst_b = 1'b0; op_b = 6'h00; z_b = 1'b0; rdy_b = 1'b0;

        //        n  op    z  r   st stb       ps io d  as dt ao il ret
        // reset, then R-type followed by LW
        vecs.push_back(v(0, 6'h23, 0, 1, 0, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 0));
        vecs.push_back(v(0, 6'h23, 0, 1, 0, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 0));
        vecs.push_back(v(1, 6'h00, 0, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 0));
        vecs.push_back(v(1, 6'h00, 0, 1, 1, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 0));
        vecs.push_back(v(1, 6'h00, 0, 1, 2, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 0));
        vecs.push_back(v(1, 6'h00, 0, 1, 4, 5'b00001, 0, 0, 1, 0, 1, 2, 0, 0));
        vecs.push_back(v(1, 6'h23, 0, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 1));
        vecs.push_back(v(1, 6'h23, 0, 1, 1, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 1));
        vecs.push_back(v(1, 6'h23, 0, 1, 2, 5'b00000, 0, 0, 1, 1, 1, 0, 0, 1));
        vecs.push_back(v(1, 6'h23, 0, 1, 3, 5'b00100, 0, 1, 1, 0, 1, 2, 0, 1));
        vecs.push_back(v(1, 6'h23, 0, 1, 4, 5'b00001, 0, 0, 0, 0, 0, 2, 0, 1));
        // BEQ taken, BNE with zero, BNE without zero
        vecs.push_back(v(1, 6'h04, 1, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 2));
        vecs.push_back(v(1, 6'h04, 1, 1, 1, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 2));
        vecs.push_back(v(1, 6'h04, 1, 1, 2, 5'b01000, 1, 0, 1, 0, 1, 1, 0, 2));
        vecs.push_back(v(1, 6'h05, 1, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 3));
        vecs.push_back(v(1, 6'h05, 1, 1, 1, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 3));
        vecs.push_back(v(1, 6'h05, 1, 1, 2, 5'b00000, 1, 0, 1, 0, 1, 4, 0, 3));
        vecs.push_back(v(1, 6'h05, 0, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 4));
        vecs.push_back(v(1, 6'h05, 0, 1, 1, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 4));
        vecs.push_back(v(1, 6'h05, 0, 1, 2, 5'b01000, 1, 0, 1, 0, 1, 4, 0, 4));
        // JAL, J
        vecs.push_back(v(1, 6'h03, 0, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 5));
        vecs.push_back(v(1, 6'h03, 0, 1, 1, 5'b01001, 2, 0, 2, 0, 2, 2, 0, 5));
        vecs.push_back(v(1, 6'h02, 0, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 6));
        vecs.push_back(v(1, 6'h02, 0, 1, 1, 5'b01000, 2, 0, 1, 0, 1, 2, 0, 6));
        // SW with a fetch stall and three MEM stall cycles
        vecs.push_back(v(1, 6'h2B, 0, 0, 0, 5'b00100, 0, 0, 1, 0, 1, 2, 0, 7));
        vecs.push_back(v(1, 6'h2B, 0, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 7));
        vecs.push_back(v(1, 6'h2B, 0, 0, 1, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 7));
        vecs.push_back(v(1, 6'h2B, 0, 0, 2, 5'b00000, 0, 0, 1, 1, 1, 0, 0, 7));
        for (int k = 0; k < 3; k++)
            vecs.push_back(v(1, 6'h2B, 0, 0, 3, 5'b00010, 0, 1, 1, 0, 1, 2, 0, 7));
        vecs.push_back(v(1, 6'h2B, 0, 1, 3, 5'b00010, 0, 1, 1, 0, 1, 2, 0, 7));
        // ADDI, ANDI (mem_ready low in EXEC/WB must not matter)
        vecs.push_back(v(1, 6'h08, 0, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 8));
        vecs.push_back(v(1, 6'h08, 0, 1, 1, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 8));
        vecs.push_back(v(1, 6'h08, 0, 0, 2, 5'b00000, 0, 0, 1, 1, 1, 0, 0, 8));
        vecs.push_back(v(1, 6'h08, 0, 0, 4, 5'b00001, 0, 0, 0, 0, 1, 2, 0, 8));
        vecs.push_back(v(1, 6'h0C, 0, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 9));
        vecs.push_back(v(1, 6'h0C, 0, 1, 1, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 9));
        vecs.push_back(v(1, 6'h0C, 0, 0, 2, 5'b00000, 0, 0, 1, 1, 1, 3, 0, 9));
        vecs.push_back(v(1, 6'h0C, 0, 0, 4, 5'b00001, 0, 0, 0, 0, 1, 2, 0, 9));
        // illegal opcode, trap holds, reset clears
        vecs.push_back(v(1, 6'h3F, 0, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 10));
        vecs.push_back(v(1, 6'h3F, 0, 1, 1, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 10));
        vecs.push_back(v(1, 6'h3F, 0, 1, 5, 5'b00000, 0, 0, 1, 0, 1, 2, 1, 10));
        vecs.push_back(v(1, 6'h00, 0, 1, 5, 5'b00000, 0, 0, 1, 0, 1, 2, 1, 10));
        vecs.push_back(v(1, 6'h00, 1, 0, 5, 5'b00000, 0, 0, 1, 0, 1, 2, 1, 10));
        vecs.push_back(v(0, 6'h00, 0, 1, 0, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 0));
        // SW interrupted by reset in the middle of a stalled MEM
        vecs.push_back(v(1, 6'h2B, 0, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 0));
        vecs.push_back(v(1, 6'h2B, 0, 1, 1, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 0));
        vecs.push_back(v(1, 6'h2B, 0, 1, 2, 5'b00000, 0, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(v(1, 6'h2B, 0, 0, 3, 5'b00010, 0, 1, 1, 0, 1, 2, 0, 0));
        vecs.push_back(v(0, 6'h2B, 0, 0, 0, 5'b00000, 0, 0, 1, 0, 1, 2, 0, 0));
        vecs.push_back(v(1, 6'h2B, 0, 1, 0, 5'b11100, 0, 0, 1, 0, 1, 2, 0, 0));

        // Apply each row: drive, queue its expectation, then compare once settled.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            nrst_a = vecs[i].n; op_a = vecs[i].op; z_a = vecs[i].z; rdy_a = vecs[i].r;
            sb.push_back(vecs[i].e);
            #2;
            act.st = st_a; act.stb = {irw_a, pcw_a, rd_a, wr_a, wreg_a};
            act.ps = pcs_a; act.io = iord_a; act.d = dest_a; act.as = asrc_a;
            act.dt = data_a; act.ao = aop_a; act.il = ill_a; act.ret = ret_a;
            want = sb.pop_front();
            n_checks++;
            if (act !== want) begin
                n_fail++;
                $display("FAIL row%0d: got st=%0d stb=%b ps=%0d io=%0b d=%0d as=%0b dt=%0d ao=%0d il=%0b ret=%0d, expected st=%0d stb=%b ps=%0d io=%0b d=%0d as=%0b dt=%0d ao=%0d il=%0b ret=%0d",
                         i, act.st, act.stb, act.ps, act.io, act.d, act.as, act.dt, act.ao, act.il, act.ret,
                         want.st, want.stb, want.ps, want.io, want.d, want.as, want.dt, want.ao, want.il, want.ret);
            end
        end

        // No-wait build held in reset so far.
        chk("b_reset_state", 32'(st_b), 32'd0);
        chk("b_reset_read", 32'(rd_b), 32'd0);

        // SW with mem_ready low throughout: FETCH and MEM each take one cycle.
        drive_b(1'b1, 6'h2B, 1'b0);
        chk("b_fetch_irw", 32'({irw_b, pcw_b, rd_b}), 32'b111);
        drive_b(1'b1, 6'h2B, 1'b0);
        chk("b_decode_state", 32'(st_b), 32'd1);
        drive_b(1'b1, 6'h2B, 1'b0);
        chk("b_exec_state", 32'(st_b), 32'd2);
        drive_b(1'b1, 6'h2B, 1'b0);
        chk("b_mem_state", 32'(st_b), 32'd3);
        chk("b_mem_wr", 32'({wr_b, iord_b}), 32'b11);
        drive_b(1'b1, 6'h02, 1'b0);
        chk("b_after_mem_state", 32'(st_b), 32'd0);
        chk("b_ret1", 32'(ret_b), 32'd1);

        // Three jumps take the 2-bit counter from 1 through 3 and back to 0.
        for (int j = 0; j < 3; j++) begin
            drive_b(1'b1, 6'h02, 1'b0);
            chk("b_jump_pcw", 32'({pcw_b, pcs_b}), 32'b110);
            drive_b(1'b1, 6'h02, 1'b0);
            chk("b_jump_fetch", 32'(st_b), 32'd0);
            chk("b_jump_ret", 32'(ret_b), 32'((j + 2) % 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
